// File: rtl/vme_mem_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vme_mem_sequencer
// Description : Sequences one host access at a time onto a VME-style register
//               block. The access is latched, one read or write strobe is
//               issued, and the block waits for the matching Done or a
//               timeout. It then returns a single-cycle acknowledge, with read
//               data or a timeout error. All outputs are registered.
//
// Ports
//   Clk          in   1    clock, rising edge
//   RstN         in   1    asynchronous active-low reset
//   HostReq      in   1    host request, held until HostAck
//   HostWr       in   1    1 = write, 0 = read (sampled with HostReq)
//   HostAddr     in   AW   access address (sampled with HostReq)
//   HostWrData   in   32   write data (sampled with HostReq)
//   HostAck      out  1    one-cycle completion pulse
//   HostErr      out  1    timeout flag, valid with HostAck
//   HostRdData   out  32   read result, valid with HostAck, held until next ACK
//   Busy         out  1    high whenever the sequencer is not idle
//   VMEAddr      out  AW   address presented to the register block
//   VMEWrData    out  32   write data presented to the register block
//   VMERdMem     out  1    one-cycle read strobe
//   VMEWrMem     out  1    one-cycle write strobe
//   VMERdData    in   32   read data, valid with VMERdDone
//   VMERdDone    in   1    read completion pulse
//   VMEWrDone    in   1    write completion pulse
//
// Revision    : 1.0 - initial release
// ============================================================================
module vme_mem_sequencer #(
    parameter int G_ADDR_WIDTH = 8,
    parameter int G_TIMEOUT    = 255
) (
    input  logic                    Clk,
    input  logic                    RstN,
    input  logic                    HostReq,
    input  logic                    HostWr,
    input  logic [G_ADDR_WIDTH-1:0] HostAddr,
    input  logic [31:0]             HostWrData,
    output logic                    HostAck,
    output logic                    HostErr,
    output logic [31:0]             HostRdData,
    output logic                    Busy,
    output logic [G_ADDR_WIDTH-1:0] VMEAddr,
    output logic [31:0]             VMEWrData,
    output logic                    VMERdMem,
    output logic                    VMEWrMem,
    input  logic [31:0]             VMERdData,
    input  logic                    VMERdDone,
    input  logic                    VMEWrDone
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_STROBE  = 2'd1;
    localparam logic [1:0]  S_WAIT    = 2'd2;
    localparam logic [1:0]  S_ACK     = 2'd3;

    localparam logic [15:0] C_TIMEOUT = 16'(G_TIMEOUT);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]              state_q,  state_d;
    logic [15:0]             cnt_q,    cnt_d;
    logic                    wr_q,     wr_d;
    logic [G_ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [31:0]             wdata_q,  wdata_d;
    logic [31:0]             rdata_q,  rdata_d;
    logic                    rd_mem_q, rd_mem_d;
    logic                    wr_mem_q, wr_mem_d;
    logic                    ack_q,    ack_d;
    logic                    err_q,    err_d;
    logic                    busy_q,   busy_d;

    // Only the Done matching the latched direction counts; the other one is
    // ignored even when both arrive together.
    logic w_done_match;
    logic w_timeout_hit;

    assign w_done_match  = wr_q ? VMEWrDone : VMERdDone;
    // A Done in the cycle the counter reaches the limit takes priority.
    assign w_timeout_hit = (cnt_q == C_TIMEOUT) && !w_done_match;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (HostReq) begin
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (w_done_match || w_timeout_hit) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output / datapath logic. Every output is computed one cycle ahead so
    // that it appears from a flop in the state it belongs to: the strobe in
    // STROBE, the acknowledge in ACK.
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rd_mem_d = 1'b0;
        wr_mem_d = 1'b0;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        busy_d   = (state_d != S_IDLE);

        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                if (HostReq) begin
                    wr_d     = HostWr;
                    addr_d   = HostAddr;
                    wdata_d  = HostWrData;
                    rd_mem_d = !HostWr;
                    wr_mem_d = HostWr;
                end
            end
            S_STROBE: begin
                cnt_d = 16'd0;
            end
            S_WAIT: begin
                if (w_done_match) begin
                    // Writes return no data, so the read register is zeroed.
                    rdata_d = wr_q ? 32'h0000_0000 : VMERdData;
                    ack_d   = 1'b1;
                end else if (w_timeout_hit) begin
                    rdata_d = 32'h0000_0000;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            S_ACK: begin
                cnt_d = 16'd0;
            end
            default: begin
                cnt_d = 16'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            cnt_q    <= 16'd0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0000_0000;
            rdata_q  <= 32'h0000_0000;
            rd_mem_q <= 1'b0;
            wr_mem_q <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_mem_q <= rd_mem_d;
            wr_mem_q <= wr_mem_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign HostAck    = ack_q;
    assign HostErr    = err_q;
    assign HostRdData = rdata_q;
    assign Busy       = busy_q;
    assign VMEAddr    = addr_q;
    assign VMEWrData  = wdata_q;
    assign VMERdMem   = rd_mem_q;
    assign VMEWrMem   = wr_mem_q;

endmodule
`default_nettype wire

// File: tb/tb_vme_mem_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vme_mem_sequencer
// Description : Scoreboard bench for vme_mem_sequencer. The driver computes,
//               for every access, the cycle and content of the strobe and of
//               the acknowledge from the latency rules, and queues them. A
//               negedge monitor pops and compares whenever the DUT presents
//               a strobe or an acknowledge, and tracks Busy, the latched
//               address/data and HostRdData against the same model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vme_mem_sequencer;

    localparam int AW = 8;
    localparam int T  = 4;

    logic          Clk;
    logic          RstN;
    logic          HostReq;
    logic          HostWr;
    logic [AW-1:0] HostAddr;
    logic [31:0]   HostWrData;
    logic          HostAck;
    logic          HostErr;
    logic [31:0]   HostRdData;
    logic          Busy;
    logic [AW-1:0] VMEAddr;
    logic [31:0]   VMEWrData;
    logic          VMERdMem;
    logic          VMEWrMem;
    logic [31:0]   VMERdData;
    logic          VMERdDone;
    logic          VMEWrDone;

    vme_mem_sequencer #(
        .G_ADDR_WIDTH (AW),
        .G_TIMEOUT    (T)
    ) dut (
        .Clk        (Clk),
        .RstN       (RstN),
        .HostReq    (HostReq),
        .HostWr     (HostWr),
        .HostAddr   (HostAddr),
        .HostWrData (HostWrData),
        .HostAck    (HostAck),
        .HostErr    (HostErr),
        .HostRdData (HostRdData),
        .Busy       (Busy),
        .VMEAddr    (VMEAddr),
        .VMEWrData  (VMEWrData),
        .VMERdMem   (VMERdMem),
        .VMEWrMem   (VMEWrMem),
        .VMERdData  (VMERdData),
        .VMERdDone  (VMERdDone),
        .VMEWrDone  (VMEWrDone)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          err;
        logic [31:0] rd;
    } ack_t;

    typedef struct {
        int            cyc;
        bit            wr;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        int            end_cyc;
    } stb_t;

    ack_t ack_q[$];
    stb_t stb_q[$];

    // Reference view of the externally visible registered state.
    int            busy_lo = -1;
    int            busy_hi = -2;
    logic [31:0]   m_rd    = 32'h0;
    logic [31:0]   m_wd    = 32'h0;
    logic [AW-1:0] m_addr  = '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    always @(negedge Clk) begin
        stb_t sb;
        ack_t ak;
        while (stb_q.size() > 0 && stb_q[0].cyc < cyc) begin
            sb = stb_q.pop_front();
            checks++; errors++;
            $display("FAIL strobe_missing: expected at cycle %0d, still absent at cycle %0d", sb.cyc, cyc);
        end
        while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
            ak = ack_q.pop_front();
            checks++; errors++;
            $display("FAIL ack_missing: expected at cycle %0d, still absent at cycle %0d", ak.cyc, cyc);
        end

        if (VMERdMem || VMEWrMem) begin
            if (stb_q.size() == 0) begin
                chk("strobe_unexpected", {62'd0, VMERdMem, VMEWrMem}, 64'd0);
            end else begin
                sb = stb_q.pop_front();
                chk("strobe_cycle", 64'(cyc), 64'(sb.cyc));
                chk("strobe_kind", {62'd0, VMERdMem, VMEWrMem}, sb.wr ? 64'd1 : 64'd2);
                m_addr  = sb.addr;
                m_wd    = sb.wd;
                busy_lo = sb.cyc;
                busy_hi = sb.end_cyc;
            end
        end

        if (HostAck) begin
            if (ack_q.size() == 0) begin
                chk("ack_unexpected", {63'd0, HostAck}, 64'd0);
            end else begin
                ak = ack_q.pop_front();
                chk("ack_cycle", 64'(cyc), 64'(ak.cyc));
                chk("ack_err", {63'd0, HostErr}, {63'd0, ak.err});
                m_rd = ak.rd;
            end
        end else begin
            chk("err_outside_ack", {63'd0, HostErr}, 64'd0);
        end

        chk("busy", {63'd0, Busy}, {63'd0, (cyc >= busy_lo && cyc <= busy_hi)});
        chk("vme_addr", {56'd0, VMEAddr}, {56'd0, m_addr});
        chk("vme_wrdata", {32'd0, VMEWrData}, {32'd0, m_wd});
        chk("host_rddata", {32'd0, HostRdData}, {32'd0, m_rd});
    end

    // ------------------------------------------------------------------------
    // Driver. Called right after a rising edge (+1); the current cycle is the
    // IDLE cycle in which HostReq is presented. d is the number of cycles
    // from the strobe to the matching Done; any d beyond T+1 arrives too late
    // and the access times out.
    // ------------------------------------------------------------------------
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int d, input bit hold,
                           input int wrong_k, input bit noise);
        int   s, e, last;
        bit   ok;
        ack_t a;
        stb_t sb;
        s    = cyc;
        ok   = (d >= 1) && (d <= T + 1);
        e    = ok ? s + d + 2 : s + T + 3;
        last = (1 + d > e - s) ? 1 + d : e - s;
        sb.cyc = s + 1; sb.wr = wr; sb.addr = addr; sb.wd = wd; sb.end_cyc = e;
        stb_q.push_back(sb);
        a.cyc = e; a.err = !ok; a.rd = (ok && !wr) ? rd : 32'h0;
        ack_q.push_back(a);
        for (int k = 0; k <= last; k++) begin
            HostReq    = (k == 0) || (hold && k <= e - s);
            HostWr     = (k == 0) ? wr : 1'($urandom_range(0, 1));
            HostAddr   = (k == 0) ? addr : AW'($urandom());
            HostWrData = (k == 0) ? wd : $urandom();
            VMERdData  = $urandom();
            VMERdDone  = 1'b0;
            VMEWrDone  = 1'b0;
            // wrong-direction Done: ignored anywhere
            if (k == wrong_k || (noise && $urandom_range(0, 3) == 0)) begin
                if (wr) VMERdDone = 1'b1; else VMEWrDone = 1'b1;
            end
            // matching Done outside WAIT: discarded
            if (noise && (k <= 1 || k >= e - s) && $urandom_range(0, 3) == 0) begin
                if (wr) VMEWrDone = 1'b1; else VMERdDone = 1'b1;
            end
            if (k == 1 + d) begin
                if (wr) begin
                    VMEWrDone = 1'b1;
                end else begin
                    VMERdDone = 1'b1;
                    VMERdData = rd;
                end
            end
            @(posedge Clk); #1;
        end
        HostReq   = 1'b0;
        VMERdDone = 1'b0;
        VMEWrDone = 1'b0;
    endtask

    task automatic idle(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            HostReq    = 1'b0;
            HostWr     = 1'($urandom_range(0, 1));
            HostAddr   = AW'($urandom());
            HostWrData = $urandom();
            VMERdData  = $urandom();
            VMERdDone  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            VMEWrDone  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge Clk); #1;
        end
        VMERdDone = 1'b0;
        VMEWrDone = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        stb_t sb0;
        HostReq = 1'b0; HostWr = 1'b0; HostAddr = '0; HostWrData = 32'h0;
        VMERdData = 32'h0; VMERdDone = 1'b0; VMEWrDone = 1'b0;
        RstN = 1'b1;
        #2 RstN = 1'b0;
        repeat (3) @(posedge Clk);
        #1 RstN = 1'b1;
        idle(2, 1'b1);

        // read, d=2, data 0x2ABC: strobe +1, ack +4
        run_txn(1'b0, 8'h10, 32'h0000_0000, 32'h0000_2ABC, 2, 1'b0, 0, 1'b0);
        idle(1, 1'b0);
        // write 0x3FFF to 0x04, d=1: ack +3
        run_txn(1'b1, 8'h04, 32'h0000_3FFF, 32'h0, 1, 1'b0, 0, 1'b0);
        idle(1, 1'b0);
        // read timeout, late Done at +9
        run_txn(1'b0, 8'h20, 32'h1234_5678, 32'hDEAD_BEEF, T + 4, 1'b0, 0, 1'b0);
        idle(2, 1'b0);
        // write, RdDone in first WAIT cycle, WrDone at d=3: ack only at +5
        run_txn(1'b1, 8'h30, 32'hCAFE_0001, 32'hBEEF_0002, 3, 1'b0, 2, 1'b0);
        idle(1, 1'b0);
        // Done in the same cycle the counter reaches the limit wins
        run_txn(1'b0, 8'h40, 32'h0, 32'hA5A5_5A5A, T + 1, 1'b0, 0, 1'b0);
        idle(1, 1'b0);
        // Done one cycle too late: timeout, Done lands in ACK
        run_txn(1'b1, 8'h41, 32'h0F0F_F0F0, 32'h0, T + 2, 1'b0, 0, 1'b0);
        idle(1, 1'b0);
        // three back-to-back writes, HostReq held, d=1: ack +3, +7, +11
        run_txn(1'b1, 8'h50, 32'h1111_1111, 32'h0, 1, 1'b1, 0, 1'b0);
        run_txn(1'b1, 8'h51, 32'h2222_2222, 32'h0, 1, 1'b1, 0, 1'b0);
        run_txn(1'b1, 8'h52, 32'h3333_3333, 32'h0, 1, 1'b1, 0, 1'b0);
        idle(2, 1'b0);

        // asynchronous reset in the middle of WAIT
        sb0.cyc = cyc + 1; sb0.wr = 1'b0; sb0.addr = 8'h55; sb0.wd = 32'h5555_AAAA;
        sb0.end_cyc = 32'h3FFF_FFFF;
        stb_q.push_back(sb0);
        HostReq = 1'b1; HostWr = 1'b0; HostAddr = 8'h55; HostWrData = 32'h5555_AAAA;
        @(posedge Clk); #1;
        HostReq = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        #2 RstN = 1'b0;
        #1;
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_ack", {63'd0, HostAck}, 64'd0);
        chk("rst_strobes", {62'd0, VMERdMem, VMEWrMem}, 64'd0);
        chk("rst_addr", {56'd0, VMEAddr}, 64'd0);
        chk("rst_rddata", {32'd0, HostRdData}, 64'd0);
        busy_hi = -2;
        m_addr  = '0;
        m_wd    = 32'h0;
        m_rd    = 32'h0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        RstN = 1'b1;
        VMERdDone = 1'b1; VMERdData = 32'h7777_7777;
        @(posedge Clk); #1;
        VMERdDone = 1'b0;
        idle(2, 1'b0);
        run_txn(1'b0, 8'h66, 32'h0, 32'h0BAD_F00D, 2, 1'b0, 0, 1'b0);
        idle(1, 1'b0);

        // randomized accesses with spurious Dones
        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom_range(0, 1)), AW'($urandom()), $urandom(), $urandom(),
                    int'($urandom_range(1, T + 3)), 1'($urandom_range(0, 1)), 0, 1'b1);
            idle(int'($urandom_range(0, 2)), 1'b1);
        end

        idle(4, 1'b0);
        chk("ack_queue_drained", 64'(ack_q.size()), 64'd0);
        chk("strobe_queue_drained", 64'(stb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
